mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Two-port arbiter/sequencer for the 16x8 synchronous RAM (enable/we/address/inout data, registered read).
//  Shares RAM between port 0 (program loader) and port 1 (SAP control path) via req/ack handshakes.
//  Drives RAM control lines and owns the bidirectional data bus; sequences the RAM's 1-cycle read latency.
// PARAMETERS
//  AW  4  address width (RAM depth 2**AW)
//  DW  8  data width
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  req0/req1    in   1   request; held high until ack seen
//  we0/we1      in   1   1=write, 0=read; stable while req high
//  addr0/addr1  in   AW  address; stable while req high
//  wdata0/wdata1 in  DW  write data; stable while req high
//  ack0/ack1    out  1   1-cycle completion pulse
//  rdata0/rdata1 out DW  read data, valid in ack cycle, held until next read on that port
//  busy         out  1   1 whenever state != IDLE
//  mem_enable   out  1   RAM enable
//  mem_we       out  1   RAM write enable
//  mem_address  out  AW  RAM address
//  mem_data     inout DW RAM data bus; driven only during write XFER, else Z
// BEHAVIOUR
//  FSM: IDLE -> XFER -> (write) RESP | (read) RD -> RESP -> IDLE. State-decoded outputs.
//  IDLE: any req high -> choose winner, latch port id, we, addr, wdata at edge; -> XFER. No req: stay.
//  XFER: mem_address=latched addr. Write: mem_enable=1, mem_we=1, mem_data=wdata, RAM commits at edge.
//        Read: mem_enable=0, mem_we=0, bus Z; RAM out_reg loads mem[addr] at edge.
//  RD: mem_enable=1, mem_we=0, address held, bus Z; rdataN <= mem_data at edge.
//  RESP: ackN=1 (winner only), mem_enable=0; -> IDLE.
//  Latency from accept edge: write ack in 2nd cycle, read ack in 3rd. One transaction per 3 (wr)/4 (rd) cycles.
//  Requester drops req at edge where ack sampled high; req still high in IDLE = new transaction.
//  Inputs sampled only in IDLE; changes mid-transaction ignored. Loser's req stays pending, no ack.
//  mem_address = 0 in IDLE/RESP. Addresses 0..2**AW-1 all legal; no wrap logic (AW bits pass through).
//  mem_enable, mem_we gated with !rst: no RAM write in any cycle with rst high.
//  Reset (any state, incl. mid-transaction): state=IDLE, ack0/1=0, rdata0/1=0, busy=0, mem_enable=0,
//    mem_we=0, mem_address=0, mem_data=Z, RR pointer=port 1 (port 0 wins first). Aborted txn: no ack.
//  Arbitration default: fixed priority, port 0 wins any tie.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: 1-bit last-grant pointer; on tie winner = port != last granted;
//    pointer updates at each accept edge. Single requester always wins.
//  Undefined: fixed priority port 0; port 1 can starve under continuous port-0 requests.
// TESTING
//  Reset 3 cycles with reqs high -> ack0/1=0, busy=0, mem_enable=0, mem_data=Z, no RAM write.
//  Port0 write addr 3 = 0xA5; port1 read addr 3 -> ack1 in 3rd cycle after accept, rdata1=0xA5.
//  Write addr 0xF=0x5A, addr 0x0=0x11; read both -> 0x5A, 0x11 (no aliasing at boundary).
//  req0,req1 high together, reads from 0x2/0x4, held: default -> port0 served repeatedly, ack1 never;
//    with MEM_ARB_ROUND_ROBIN_EN -> ack0, ack1 alternate, port0 first.
//  rst pulsed 1 cycle while in RD -> no ack, IDLE next, rdata=0; next read addr 3 returns 0xA5.
//  rst pulsed during write XFER to addr 7 (was 0x00, data 0xFF) -> read addr 7 returns 0x00.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Two-port req/ack arbiter and sequencer for a 16x8 registered-read RAM.
// Optional `MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mem_access_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_enable,
  output logic          mem_we,
  output logic [AW-1:0] mem_address,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RD,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic          sel;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          win;
  logic          accept;
  logic          drive;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last;

  // On a tie, grant the port that did not win last time.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last;
    else              win = req1;
  end
`else
  always_comb begin
    win = ~req0;
  end
`endif

  assign accept = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last    <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel     <= win;
        we_q    <= win ? we1 : we0;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last    <= win;
`endif
      end
      if (state == RD) begin
        if (sel) rdata1 <= mem_data;
        else     rdata0 <= mem_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = XFER;
      XFER: state_nxt = we_q ? RESP : RD;
      RD:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything visible to the RAM or requesters is forced quiet in reset.
  always_comb begin
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b0;
    mem_enable  = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    drive       = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: ;
        XFER: begin
          mem_address = addr_q;
          mem_enable  = we_q;
          mem_we      = we_q;
          drive       = we_q;
        end
        RD: begin
          mem_address = addr_q;
          mem_enable  = 1'b1;
        end
        RESP: begin
          ack0 = ~sel;
          ack1 = sel;
        end
        default: ;
      endcase
    end
  end

  assign mem_data = drive ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a RAM model.
// Set MEM_ARB_ROUND_ROBIN_EN to check the round-robin arbitration variant.
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0;
  logic [3:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic       req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       ack0, ack1, busy;
  logic [7:0] rdata0, rdata1;
  logic       mem_enable, mem_we;
  logic [3:0] mem_address;
  wire  [7:0] mem_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [16];
  logic [7:0] out_reg;

  always #5 clk = ~clk;

  mem_access_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_enable(mem_enable), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data(mem_data)
  );

  always @(posedge clk) begin
    if (mem_enable && mem_we) ram[mem_address] <= mem_data;
    out_reg <= ram[mem_address];
  end

  assign mem_data = (mem_enable && !mem_we) ? out_reg : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transaction on a port and check ack latency and read data.
  task automatic txn(input string tag, input bit port, input bit we,
                     input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input int exp_lat);
    int lat;
    bit other;
    lat = 0;
    other = 1'b0;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      tick();
      if (port ? ack1 : ack0) lat = n;
      if (port ? ack0 : ack1) other = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_other_ack"}, other, 1'b0);
    if (!we) check({tag, "_rdata"}, port ? rdata1 : rdata0, exp_rd);
    tick();
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  int c0, c1;
  bit first1;
  bit alt_ok;
  bit prev;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    rst = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    we0 = 1'b1;
    we1 = 1'b1;
    wdata0 = 8'hEE;
    wdata1 = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ack0", ack0, 1'b0);
      check("rst_ack1", ack1, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_en", mem_enable, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_address, 4'h0);
      check("rst_rdata0", rdata0, 8'h00);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    we0 = 1'b0;
    we1 = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_no_write", ram[0], 8'h00);

    txn("wr3", 1'b0, 1'b1, 4'h3, 8'hA5, 8'h00, 2);
    check("ram3", ram[3], 8'hA5);
    txn("rd3", 1'b1, 1'b0, 4'h3, 8'h00, 8'hA5, 3);
    txn("wrF", 1'b0, 1'b1, 4'hF, 8'h5A, 8'h00, 2);
    txn("wr0", 1'b1, 1'b1, 4'h0, 8'h11, 8'h00, 2);
    txn("rdF", 1'b0, 1'b0, 4'hF, 8'h00, 8'h5A, 3);
    txn("rd0", 1'b1, 1'b0, 4'h0, 8'h00, 8'h11, 3);
    txn("wr2", 1'b0, 1'b1, 4'h2, 8'h22, 8'h00, 2);
    txn("wr4", 1'b1, 1'b1, 4'h4, 8'h44, 8'h00, 2);

    c0 = 0;
    c1 = 0;
    first1 = 1'b0;
    alt_ok = 1'b1;
    prev = 1'b1;
    we0 = 1'b0; addr0 = 4'h2;
    we1 = 1'b0; addr1 = 4'h4;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (ack0 || ack1) begin
        if (c0 + c1 == 0) first1 = ack1;
        if (ack1 == prev) alt_ok = 1'b0;
        prev = ack1;
      end
      if (ack0) c0++;
      if (ack1) c1++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_first_port", first1, 1'b0);
    check("tie_rdata0", rdata0, 8'h22);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("rr_ack0_cnt", c0, 2);
    check("rr_ack1_cnt", c1, 2);
    check("rr_alternate", alt_ok, 1'b1);
    check("rr_rdata1", rdata1, 8'h44);
`else
    check("fp_ack0_cnt", c0, 4);
    check("fp_ack1_cnt", c1, 0);
`endif
    tick();
    check("tie_idle", busy, 1'b0);

    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
    tick();
    check("abort_rd_xfer", busy, 1'b1);
    tick();
    check("abort_rd_en", mem_enable, 1'b1);
    rst = 1'b1;
    req1 = 1'b0;
    #1;
    check("abort_rd_en_gate", mem_enable, 1'b0);
    check("abort_rd_ack_gate", ack1, 1'b0);
    tick();
    rst = 1'b0;
    check("abort_rd_busy", busy, 1'b0);
    check("abort_rd_rdata1", rdata1, 8'h00);
    check("abort_rd_rdata0", rdata0, 8'h00);
    tick();
    check("abort_rd_noack", ack1, 1'b0);
    txn("rd3_again", 1'b1, 1'b0, 4'h3, 8'h00, 8'hA5, 3);

    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 8'hFF;
    tick();
    check("abort_wr_we", mem_we, 1'b1);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    check("abort_wr_we_gate", mem_we, 1'b0);
    check("abort_wr_en_gate", mem_enable, 1'b0);
    tick();
    rst = 1'b0;
    check("abort_wr_busy", busy, 1'b0);
    tick();
    check("abort_wr_noack", ack0, 1'b0);
    txn("rd7", 1'b0, 1'b0, 4'h7, 8'h00, 8'h00, 3);
    check("ram7", ram[7], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
